// File: rtl/branch_pred_resolve_if.sv
// rtl/branch_pred_resolve_if.sv - fetch/EX prediction and resolution signal bundle
interface branch_pred_resolve_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      PCF;
  logic             PredictF;
  logic [31:0]      PredictTarget;
  logic             StallD;
  logic             FlushD;
  logic             StallE;
  logic             FlushE;
  logic [31:0]      PCE;
  logic             BranchTypeE;
  logic             BranchE;
  logic [31:0]      BranchTarget;
  logic [31:0]      NPC;
  logic             RedirectE;
  logic             FlushPredD;
  logic             FlushPredE;
  logic [CNT_W-1:0] BranchCnt;
  logic [CNT_W-1:0] MissCnt;

  modport master (
    output PCF, PredictF, PredictTarget, StallD, FlushD, StallE, FlushE,
           PCE, BranchTypeE, BranchE, BranchTarget,
    input  NPC, RedirectE, FlushPredD, FlushPredE, BranchCnt, MissCnt
  );

  modport slave (
    input  PCF, PredictF, PredictTarget, StallD, FlushD, StallE, FlushE,
           PCE, BranchTypeE, BranchE, BranchTarget,
    output NPC, RedirectE, FlushPredD, FlushPredE, BranchCnt, MissCnt
  );
endinterface

// File: rtl/branch_pred_resolve.sv
// rtl/branch_pred_resolve.sv - carries BTB predictions F->D->E and resolves them in EX
// Redirects fetch and flushes D/E on a misprediction; keeps saturating branch/miss counters.
module branch_pred_resolve #(
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  branch_pred_resolve_if.slave bp
);

  logic             r_valid_d, r_pred_d;
  logic [31:0]      r_tgt_d;
  logic             r_valid_e, r_pred_e;
  logic [31:0]      r_tgt_e;
  logic [CNT_W-1:0] r_branch_cnt, r_miss_cnt;

  logic             w_resolve;
  logic             w_taken;
  logic             w_redirect;
  logic [31:0]      w_redirect_pc;

  assign w_resolve = r_valid_e & ~bp.StallE;
  assign w_taken   = bp.BranchTypeE & bp.BranchE;

  // A not-taken prediction on a non-branch is simply sequential flow, never a redirect.
  always_comb begin
    w_redirect    = 1'b0;
    w_redirect_pc = bp.BranchTarget;
    if (w_resolve) begin
      if (r_pred_e) begin
        if (w_taken) begin
          w_redirect = (r_tgt_e != bp.BranchTarget);
        end else begin
          w_redirect    = 1'b1;
          w_redirect_pc = bp.PCE + 32'd4;
        end
      end else begin
        w_redirect = w_taken;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_d <= 1'b0;
      r_pred_d  <= 1'b0;
      r_tgt_d   <= 32'd0;
    end else if (bp.FlushD | w_redirect) begin
      r_valid_d <= 1'b0;
      r_pred_d  <= 1'b0;
      r_tgt_d   <= 32'd0;
    end else if (!bp.StallD) begin
      r_valid_d <= 1'b1;
      r_pred_d  <= bp.PredictF;
      r_tgt_d   <= bp.PredictTarget;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_e <= 1'b0;
      r_pred_e  <= 1'b0;
      r_tgt_e   <= 32'd0;
    end else if (bp.FlushE | w_redirect) begin
      r_valid_e <= 1'b0;
      r_pred_e  <= 1'b0;
      r_tgt_e   <= 32'd0;
    end else if (!bp.StallE) begin
      r_valid_e <= r_valid_d;
      r_pred_e  <= r_pred_d;
      r_tgt_e   <= r_tgt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else if (w_resolve) begin
      if (bp.BranchTypeE && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_redirect && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign bp.RedirectE  = w_redirect;
  assign bp.FlushPredD = w_redirect;
  assign bp.FlushPredE = w_redirect;
  assign bp.NPC        = w_redirect  ? w_redirect_pc :
                         bp.PredictF ? bp.PredictTarget :
                                       bp.PCF + 32'd4;
  assign bp.BranchCnt  = r_branch_cnt;
  assign bp.MissCnt    = r_miss_cnt;

endmodule

// File: tb/tb_branch_pred_resolve.sv
// tb/tb_branch_pred_resolve.sv - directed self-checking bench for branch_pred_resolve
module tb_branch_pred_resolve;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  branch_pred_resolve_if #(.CNT_W(CNT_W)) bif ();

  branch_pred_resolve #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    bif.PCE          = 32'd0;
    bif.BranchTypeE  = 1'b0;
    bif.BranchE      = 1'b0;
    bif.BranchTarget = 32'd0;
  endtask

  task automatic set_ex(input logic [31:0] pce, input logic bt, input logic be, input logic [31:0] tgt);
    bif.PCE          = pce;
    bif.BranchTypeE  = bt;
    bif.BranchE      = be;
    bif.BranchTarget = tgt;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bif.PCF = 32'h100; bif.PredictF = 1'b0; bif.PredictTarget = 32'd0;
    bif.StallD = 1'b0; bif.FlushD = 1'b0; bif.StallE = 1'b0; bif.FlushE = 1'b0;
    clear_ex();
    #12;
    check("rst_redirect", {31'd0, bif.RedirectE}, 32'd0);
    check("rst_flushd",   {31'd0, bif.FlushPredD}, 32'd0);
    check("rst_flushe",   {31'd0, bif.FlushPredE}, 32'd0);
    check("rst_bcnt",     32'(bif.BranchCnt), 32'd0);
    check("rst_mcnt",     32'(bif.MissCnt), 32'd0);
    check("rst_npc",      bif.NPC, 32'h104);
    step();
    rst = 1'b0;
    step();

    // correct taken prediction
    bif.PCF = 32'h30; bif.PredictF = 1'b1; bif.PredictTarget = 32'h40;
    #1 check("t1_npc_pred", bif.NPC, 32'h40);
    step();
    bif.PredictF = 1'b0;
    step();
    set_ex(32'h30, 1'b1, 1'b1, 32'h40);
    check("t1_redirect", {31'd0, bif.RedirectE}, 32'd0);
    check("t1_npc_seq",  bif.NPC, 32'h34);
    step();
    clear_ex();
    check("t1_bcnt", 32'(bif.BranchCnt), 32'd1);
    check("t1_mcnt", 32'(bif.MissCnt), 32'd0);

    // false taken, also with StallD and a competing F prediction
    bif.PCF = 32'h10; bif.PredictF = 1'b1; bif.PredictTarget = 32'h200;
    step();
    bif.PCF = 32'h200; bif.PredictF = 1'b0;
    step();
    bif.StallD = 1'b1; bif.PredictF = 1'b1; bif.PredictTarget = 32'h300;
    set_ex(32'h10, 1'b1, 1'b0, 32'h0);
    check("t2_redirect", {31'd0, bif.RedirectE}, 32'd1);
    check("t2_flushd",   {31'd0, bif.FlushPredD}, 32'd1);
    check("t2_flushe",   {31'd0, bif.FlushPredE}, 32'd1);
    check("t2_npc",      bif.NPC, 32'h14);
    step();
    bif.StallD = 1'b0; bif.PredictF = 1'b0;
    set_ex(32'h10, 1'b1, 1'b1, 32'h999);
    check("t2_e_cleared", {31'd0, bif.RedirectE}, 32'd0);
    check("t2_mcnt", 32'(bif.MissCnt), 32'd1);
    check("t2_bcnt", 32'(bif.BranchCnt), 32'd2);
    step();
    check("t2_d_cleared", {31'd0, bif.RedirectE}, 32'd0);
    clear_ex();
    check("t2_mcnt_hold", 32'(bif.MissCnt), 32'd1);

    // missed taken
    bif.PCF = 32'h20;
    step();
    step();
    set_ex(32'h20, 1'b1, 1'b1, 32'h80);
    check("t3_redirect", {31'd0, bif.RedirectE}, 32'd1);
    check("t3_npc",      bif.NPC, 32'h80);
    step();
    clear_ex();
    check("t3_bcnt", 32'(bif.BranchCnt), 32'd3);
    check("t3_mcnt", 32'(bif.MissCnt), 32'd2);
    step();
    step();

    // stall holds resolution, release gives exactly one redirect
    bif.PCF = 32'h50; bif.PredictF = 1'b1; bif.PredictTarget = 32'h500;
    step();
    bif.PredictF = 1'b0;
    step();
    bif.StallE = 1'b1;
    set_ex(32'h50, 1'b1, 1'b0, 32'h0);
    check("t4_stall_redirect", {31'd0, bif.RedirectE}, 32'd0);
    step();
    check("t4_stall_redirect2", {31'd0, bif.RedirectE}, 32'd0);
    check("t4_stall_bcnt", 32'(bif.BranchCnt), 32'd3);
    check("t4_stall_mcnt", 32'(bif.MissCnt), 32'd2);
    bif.StallE = 1'b0;
    #1;
    check("t4_rel_redirect", {31'd0, bif.RedirectE}, 32'd1);
    check("t4_rel_npc",      bif.NPC, 32'h54);
    step();
    check("t4_once", {31'd0, bif.RedirectE}, 32'd0);
    check("t4_bcnt", 32'(bif.BranchCnt), 32'd4);
    check("t4_mcnt", 32'(bif.MissCnt), 32'd3);
    clear_ex();
    step();

    // FlushE drops a would-be mispredict
    bif.PCF = 32'h60; bif.PredictF = 1'b1; bif.PredictTarget = 32'h600;
    step();
    bif.PredictF = 1'b0; bif.FlushE = 1'b1;
    step();
    bif.FlushE = 1'b0;
    set_ex(32'h60, 1'b1, 1'b0, 32'h0);
    check("t4_flushe_redirect", {31'd0, bif.RedirectE}, 32'd0);
    clear_ex();
    step();
    check("t4_flushe_mcnt", 32'(bif.MissCnt), 32'd3);
    check("t4_flushe_bcnt", 32'(bif.BranchCnt), 32'd4);

    // drive both counters into saturation
    for (int i = 0; i < 13; i++) begin
      set_ex(32'h70, 1'b1, 1'b1, 32'h700);
      step();
      clear_ex();
      step();
      step();
    end
    check("t5_mcnt_sat", 32'(bif.MissCnt), 32'd15);
    check("t5_bcnt_sat", 32'(bif.BranchCnt), 32'd15);

    // PC wrap on both fetch and EX paths
    bif.PCF = 32'hFFFF_FFFC; bif.PredictF = 1'b0;
    #1 check("t5_pcf_wrap", bif.NPC, 32'h0);
    bif.PredictF = 1'b1; bif.PredictTarget = 32'h8;
    step();
    bif.PredictF = 1'b0; bif.PCF = 32'h8;
    step();
    set_ex(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
    check("t5_wrap_redirect", {31'd0, bif.RedirectE}, 32'd1);
    check("t5_pce_wrap", bif.NPC, 32'h0);
    step();
    clear_ex();
    check("t5_mcnt_hold", 32'(bif.MissCnt), 32'd15);
    step();
    step();

    // asynchronous reset in the middle of a redirect
    bif.PCF = 32'h100;
    set_ex(32'h90, 1'b1, 1'b1, 32'h900);
    check("t6_pre_redirect", {31'd0, bif.RedirectE}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_redirect", {31'd0, bif.RedirectE}, 32'd0);
    check("t6_bcnt", 32'(bif.BranchCnt), 32'd0);
    check("t6_mcnt", 32'(bif.MissCnt), 32'd0);
    check("t6_npc",  bif.NPC, 32'h104);
    clear_ex();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
